// File: rtl/up_counter_mod.sv
// Modulo up-counter with a small run-control FSM (IDLE / RUN / DONE).
// Counts from 0 up to max_val while up is high. In free-run mode it wraps
// back to 0 and pulses wrap; in one-shot mode it parks at max_val and
// raises done. The wrap output can drive the up input of a following
// stage to build a wider counter.
module up_counter_mod #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             start,
  input  logic             oneshot,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] max_val,
  output logic [WIDTH-1:0] cout,
  output logic             tc,
  output logic             wrap,
  output logic             done,
  output logic             ovf,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  state_t state;
  logic   mode;   // 1 = one-shot, 0 = free-run; captured when start is accepted

  // Terminal-count flag follows the live max_val, so it is combinational.
  assign tc = (state == RUN) && (cout == max_val);

  // Run-control FSM, count register and registered status outputs.
  // Priority at each edge: reset > clr > start-accept (with optional load) > load > count.
  // A start that arrives together with load launches the run from load_val
  // instead of 0; outside of a start, load only overwrites the count.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      mode  <= 1'b0;
      cout  <= '0;
      wrap  <= 1'b0;
      done  <= 1'b0;
      ovf   <= 1'b0;
      busy  <= 1'b0;
    end else if (clr) begin
      state <= IDLE;
      cout  <= '0;
      wrap  <= 1'b0;
      done  <= 1'b0;
      ovf   <= 1'b0;
      busy  <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (start && (state != RUN)) begin
        state <= RUN;
        busy  <= 1'b1;
        done  <= 1'b0;
        mode  <= oneshot;
        cout  <= load ? load_val : '0;
      end else if (load) begin
        cout <= load_val;
      end else if ((state == RUN) && up) begin
        if (cout == max_val) begin
          if (mode) begin
            // One-shot: park at the limit and hand over to DONE.
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            cout <= '0;
            wrap <= 1'b1;
            ovf  <= 1'b1;
          end
        end else if (cout == ALL_ONES) begin
          // Count sits above the limit (after a load or a max_val change):
          // roll over modulo 2^WIDTH in either mode and keep climbing.
          cout <= '0;
          wrap <= 1'b1;
          ovf  <= 1'b1;
        end else begin
          cout <= cout + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_up_counter_mod.sv
// Bench for up_counter_mod: directed scenarios with literal expectations,
// then randomized traffic, all cross-checked every cycle against a
// behavioural model of the counter.
module tb_up_counter_mod;

  localparam int W   = 4;
  localparam int MOD = 1 << W;

  logic         clk = 1'b0;
  logic         reset, clr, start, oneshot, up, load;
  logic [W-1:0] load_val, max_val;
  logic [W-1:0] cout;
  logic         tc, wrap, done, ovf, busy;

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  up_counter_mod #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .clr(clr), .start(start), .oneshot(oneshot),
    .up(up), .load(load), .load_val(load_val), .max_val(max_val),
    .cout(cout), .tc(tc), .wrap(wrap), .done(done), .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0=idle 1=running 2=finished.
  int m_cnt   = 0;
  int m_phase = 0;
  bit m_once  = 0;
  bit m_wrap  = 0;
  bit m_ovf   = 0;
  int m_next;

  always @(posedge clk) begin
    m_wrap = 0;
    if (!reset) begin
      m_cnt = 0; m_phase = 0; m_once = 0; m_ovf = 0;
    end else if (clr) begin
      m_cnt = 0; m_phase = 0; m_ovf = 0;
    end else if (start && m_phase != 1) begin
      m_phase = 1;
      m_once  = oneshot;
      m_cnt   = load ? int'(load_val) : 0;
    end else if (load) begin
      m_cnt = int'(load_val);
    end else if (m_phase == 1 && up) begin
      if (m_once && m_cnt == int'(max_val)) begin
        m_phase = 2;
      end else begin
        m_next = (m_cnt == int'(max_val)) ? 0 : (m_cnt + 1) % MOD;
        if (m_next == 0) begin
          m_wrap = 1;
          m_ovf  = 1;
        end
        m_cnt = m_next;
      end
    end
  end

  // Compare every output against the model away from the active edge.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("model_cout", int'(cout), m_cnt);
      chk("model_tc",   int'(tc),   int'(m_phase == 1 && m_cnt == int'(max_val)));
      chk("model_wrap", int'(wrap), int'(m_wrap));
      chk("model_done", int'(done), int'(m_phase == 2));
      chk("model_ovf",  int'(ovf),  int'(m_ovf));
      chk("model_busy", int'(busy), int'(m_phase == 1));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int fr_seq[7]  = '{1, 2, 3, 4, 5, 0, 1};
  int os_seq[5]  = '{1, 2, 3, 3, 3};
  int ld_seq[12] = '{10, 11, 12, 13, 14, 15, 0, 1, 2, 3, 4, 5};
  int guard;

  initial begin
    reset = 1'b0; clr = 1'b0; start = 1'b0; oneshot = 1'b0; up = 1'b1;
    load = 1'b0; load_val = '0; max_val = 4'd5;

    // Reset held for three edges, then idle with up asserted.
    cyc(); chk_on = 1'b1;
    cyc(); cyc();
    chk("rst_cout", int'(cout), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_flags", int'({done, wrap, ovf}), 0);
    reset = 1'b1;
    cyc(); cyc();
    chk("idle_up_cout", int'(cout), 0);
    chk("idle_busy", int'(busy), 0);

    // Free-run wrap at max_val=5.
    start = 1'b1; oneshot = 1'b0;
    cyc();
    start = 1'b0;
    chk("fr_start_cout", int'(cout), 0);
    chk("fr_start_busy", int'(busy), 1);
    for (int i = 0; i < 7; i++) begin
      cyc();
      chk("fr_cout", int'(cout), fr_seq[i]);
      chk("fr_wrap", int'(wrap), int'(i == 5));
      chk("fr_tc", int'(tc), int'(fr_seq[i] == 5));
      chk("fr_ovf", int'(ovf), int'(i >= 5));
    end
    clr = 1'b1; cyc(); clr = 1'b0;
    chk("clr_cout", int'(cout), 0);
    chk("clr_ovf", int'(ovf), 0);

    // One-shot at max_val=3.
    max_val = 4'd3; oneshot = 1'b1; start = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("os_cout", int'(cout), os_seq[i]);
      chk("os_done", int'(done), int'(i >= 3));
      chk("os_busy", int'(busy), int'(i < 3));
      chk("os_wrap", int'(wrap), 0);
    end
    start = 1'b1; cyc(); start = 1'b0;
    chk("os_restart_cout", int'(cout), 0);
    chk("os_restart_busy", int'(busy), 1);
    chk("os_restart_done", int'(done), 0);

    // Enable gating and load above the limit.
    clr = 1'b1; cyc(); clr = 1'b0;
    max_val = 4'd5; oneshot = 1'b0; start = 1'b1;
    cyc(); start = 1'b0;
    cyc(); cyc();
    chk("gate_pre", int'(cout), 2);
    up = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("gate_hold", int'(cout), 2);
    end
    up = 1'b1; load = 1'b1; load_val = 4'd9;
    cyc(); load = 1'b0;
    chk("load_cout", int'(cout), 9);
    for (int i = 0; i < 12; i++) begin
      cyc();
      chk("load_cout_seq", int'(cout), ld_seq[i]);
      chk("load_wrap", int'(wrap), int'(i == 6));
      chk("load_ovf", int'(ovf), int'(i >= 6));
    end

    // clr, load and start on the same edge.
    clr = 1'b1; load = 1'b1; start = 1'b1; load_val = 4'd7;
    cyc(); clr = 1'b0;
    chk("prio_cout", int'(cout), 0);
    chk("prio_busy", int'(busy), 0);
    chk("prio_ovf", int'(ovf), 0);
    // start with load in IDLE launches from load_val.
    cyc(); start = 1'b0; load = 1'b0;
    chk("stld_cout", int'(cout), 7);
    chk("stld_busy", int'(busy), 1);

    // Run to cout=4 after a rollover, then reset mid-count.
    guard = 0;
    do begin
      cyc();
      guard++;
    end while (!(cout == 4'd4 && ovf) && guard < 40);
    chk("reach4_timeout", int'(guard < 40), 1);
    reset = 1'b0; cyc(); reset = 1'b1;
    chk("midrst_cout", int'(cout), 0);
    chk("midrst_flags", int'({busy, done, wrap, ovf}), 0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("postrst_cout", int'(cout), 0);
    end

    // Randomized traffic checked by the model.
    for (int i = 0; i < 3000; i++) begin
      reset    = ($urandom_range(0, 199) != 0);
      clr      = ($urandom_range(0, 59) == 0);
      start    = ($urandom_range(0, 15) == 0);
      load     = ($urandom_range(0, 19) == 0);
      up       = ($urandom_range(0, 3) != 0);
      oneshot  = 1'($urandom);
      load_val = 4'($urandom);
      if ($urandom_range(0, 31) == 0) max_val = 4'($urandom_range(0, 15));
      cyc();
    end
    reset = 1'b1; clr = 1'b0; start = 1'b0; load = 1'b0;
    cyc(); cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
